// File: rtl/queue_rd_stage_if.sv
// Handshake bundle between the read stage, the queue controller/RAM and the downstream consumer.
// Signal names keep the read stage's point of view (i_ = into the stage, o_ = out of it).
interface queue_rd_stage_if #(
  parameter int W = 32
);
  logic         i_empty;
  logic         o_pop;
  logic [W-1:0] i_rd_data;
  logic         o_vld;
  logic [W-1:0] o_data;
  logic         i_ack;

  modport master (
    input  i_empty,
    input  i_rd_data,
    input  i_ack,
    output o_pop,
    output o_vld,
    output o_data
  );

  modport slave (
    output i_empty,
    output i_rd_data,
    output i_ack,
    input  o_pop,
    input  o_vld,
    input  o_data
  );
endinterface

// File: rtl/queue_rd_stage.sv
// Read-side consumer of a RAM-backed queue: issues pops, absorbs the one-cycle RAM latency
// and feeds a 2-entry skid buffer presented downstream on a valid/ack interface.
module queue_rd_stage #(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  queue_rd_stage_if.master  bus,
  output logic              o_idle
);

  logic         r_inflight;
  logic [W-1:0] r_buf [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_cnt;

  logic         w_deq;
  logic [2:0]   w_occ;
  logic [2:0]   w_occ_net;

  assign bus.o_vld  = (r_cnt != 2'd0);
  assign bus.o_data = r_buf[r_head];
  assign w_deq      = bus.o_vld & bus.i_ack;

  // Words buffered plus in flight, minus the one leaving this cycle, must stay below 2 to pop.
  assign w_occ     = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign w_occ_net = w_occ - {2'b00, w_deq};
  assign bus.o_pop = ~bus.i_empty & (w_occ_net < 3'd2);

  assign o_idle = (r_cnt == 2'd0) & ~r_inflight;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= bus.o_pop;
      if (w_deq)
        r_head <= ~r_head;
      if (r_inflight)
        r_tail <= ~r_tail;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_deq};
    end
  end

  // Storage is not reset; its contents are only observed while r_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (r_inflight)
      r_buf[r_tail] <= bus.i_rd_data;
  end

  a_cnt_max: assert property (@(posedge clk) disable iff (!arst_n)
    r_cnt <= 2'd2);

  a_no_overrun: assert property (@(posedge clk) disable iff (!arst_n)
    !(r_inflight && (r_cnt == 2'd2) && !w_deq));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!arst_n)
    !(bus.o_pop && bus.i_empty));

  a_stall_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (bus.o_vld && !bus.i_ack) |=> (bus.o_vld && $stable(bus.o_data)));

endmodule
